// File: rtl/mma_pkg.sv
// Shared constants and types for the tiled matrix-multiply scheduler.
// State codes stay plain localparams so older tooling and checkers can match them.
package mma_pkg;

  localparam int N          = 4;
  localparam int DIM_W_DEF  = 8;
  localparam int PERF_W_DEF = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_STORE  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef struct packed {
    logic [DIM_W_DEF-1:0] row;
    logic [DIM_W_DEF-1:0] col;
    logic [DIM_W_DEF-1:0] k;
  } tile_idx_t;

endpackage

// File: rtl/mma_tile_index_counter.sv
// Three-level nested wrap counter walking C tiles row-major with k innermost.
// The last_* flags compare against the job's latched tile counts.
module mma_tile_index_counter
  import mma_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc_k,
  input  logic             inc_tile,
  input  logic [DIM_W-1:0] m_tiles,
  input  logic [DIM_W-1:0] k_tiles,
  input  logic [DIM_W-1:0] p_tiles,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] k,
  output logic             last_k,
  output logic             last_tile
);

  localparam logic [DIM_W-1:0] ONE = 1;

  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] k_q, k_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    k_d   = k_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
      k_d   = '0;
    end else if (inc_tile) begin
      k_d = '0;
      if (col_q == p_tiles - ONE) begin
        col_d = '0;
        row_d = (row_q == m_tiles - ONE) ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end else if (inc_k) begin
      k_d = k_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
      k_q   <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      k_q   <= k_d;
    end
  end

  assign row       = row_q;
  assign col       = col_q;
  assign k         = k_q;
  assign last_k    = (k_q == k_tiles - ONE);
  assign last_tile = (row_q == m_tiles - ONE) && (col_q == p_tiles - ONE);

endmodule

// File: rtl/mma_tile_scheduler.sv
// Sequences N x N tile products for C = A*B over the systolic array and hands
// each finished C tile to the store path.
module mma_tile_scheduler
  import mma_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIM_W-1:0]  cfg_m_tiles,
  input  logic [DIM_W-1:0]  cfg_k_tiles,
  input  logic [DIM_W-1:0]  cfg_p_tiles,
  input  logic              abort,
  output logic              array_start,
  input  logic              array_done,
  output logic              acc_clear,
  output logic [DIM_W-1:0]  tile_row,
  output logic [DIM_W-1:0]  tile_col,
  output logic [DIM_W-1:0]  tile_k,
  output logic              store_valid,
  input  logic              store_ready,
  output logic              busy,
  output logic              job_done,
  output logic              err,
  output logic [PERF_W-1:0] perf_cycles
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; store_valid holds with stable indices until accepted or aborted.
  logic [2:0]        state_q, state_d;
  logic [DIM_W-1:0]  m_q, m_d, k_q, k_d, p_q, p_d;
  logic              err_q, err_d;
  logic              abort_pend_q, abort_pend_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              idx_clear, inc_k, inc_tile, last_k, last_tile;

  mma_tile_index_counter #(.DIM_W(DIM_W)) u_idx (
    .clk       (clk),
    .reset     (reset),
    .clear     (idx_clear),
    .inc_k     (inc_k),
    .inc_tile  (inc_tile),
    .m_tiles   (m_q),
    .k_tiles   (k_q),
    .p_tiles   (p_q),
    .row       (tile_row),
    .col       (tile_col),
    .k         (tile_k),
    .last_k    (last_k),
    .last_tile (last_tile)
  );

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    k_d          = k_q;
    p_d          = p_q;
    err_d        = err_q;
    abort_pend_d = abort_pend_q;
    perf_d       = (state_q != ST_IDLE && perf_q != '1) ? perf_q + 1'b1 : perf_q;
    idx_clear    = 1'b0;
    inc_k        = 1'b0;
    inc_tile     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          m_d          = cfg_m_tiles;
          k_d          = cfg_k_tiles;
          p_d          = cfg_p_tiles;
          idx_clear    = 1'b1;
          err_d        = 1'b0;
          perf_d       = '0;
          abort_pend_d = 1'b0;
          if (cfg_m_tiles == '0 || cfg_k_tiles == '0 || cfg_p_tiles == '0) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The array is never abandoned mid-product: abort only takes effect at done.
        if (abort) begin
          err_d        = 1'b1;
          abort_pend_d = 1'b1;
        end
        if (array_done) begin
          if (abort || abort_pend_q) begin
            state_d = ST_FINISH;
          end else if (!last_k) begin
            inc_k   = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (store_ready) begin
          inc_tile = 1'b1;
          state_d  = last_tile ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: begin
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (array_done && state_q != ST_WAIT) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      m_q          <= '0;
      k_q          <= '0;
      p_q          <= '0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      perf_q       <= '0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      k_q          <= k_d;
      p_q          <= p_d;
      err_q        <= err_d;
      abort_pend_q <= abort_pend_d;
      perf_q       <= perf_d;
    end
  end

  assign cfg_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign array_start = (state_q == ST_ISSUE) && !abort;
  assign store_valid = (state_q == ST_STORE) && !abort;
  assign job_done    = (state_q == ST_FINISH);
  assign acc_clear   = busy && (tile_k == '0);
  assign err         = err_q;
  assign perf_cycles = perf_q;

endmodule

// File: tb/tb_mma_tile_scheduler.sv
// Directed bench for mma_tile_scheduler: a responder models the array latency,
// a negedge monitor counts starts/stores and checks store order against exp_q.
module tb_mma_tile_scheduler;

  localparam int DIM_W  = 8;
  localparam int PERF_W = 32;
  localparam int W      = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [DIM_W-1:0]  cfg_m_tiles = '0;
  logic [DIM_W-1:0]  cfg_k_tiles = '0;
  logic [DIM_W-1:0]  cfg_p_tiles = '0;
  logic              abort = 1'b0;
  logic              array_start;
  logic              array_done;
  logic              acc_clear;
  logic [DIM_W-1:0]  tile_row, tile_col, tile_k;
  logic              store_valid;
  logic              store_ready = 1'b0;
  logic              busy;
  logic              job_done;
  logic              err;
  logic [PERF_W-1:0] perf_cycles;

  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  assign array_done = resp_done | spur_done;

  int checks = 0;
  int failures = 0;
  int starts_n = 0, clears_n = 0, stores_n = 0, dones_n = 0;
  int done_lat = 3;
  int b_s, b_c, b_st, b_d, n;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;

  mma_tile_scheduler #(.DIM_W(DIM_W), .PERF_W(PERF_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_m_tiles (cfg_m_tiles),
    .cfg_k_tiles (cfg_k_tiles),
    .cfg_p_tiles (cfg_p_tiles),
    .abort       (abort),
    .array_start (array_start),
    .array_done  (array_done),
    .acc_clear   (acc_clear),
    .tile_row    (tile_row),
    .tile_col    (tile_col),
    .tile_k      (tile_k),
    .store_valid (store_valid),
    .store_ready (store_ready),
    .busy        (busy),
    .job_done    (job_done),
    .err         (err),
    .perf_cycles (perf_cycles)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // array responder: done arrives done_lat edges after the start cycle
  always begin
    @(negedge clk);
    if (array_start) begin
      for (int i = 0; i < done_lat && !reset; i++) @(posedge clk);
      if (!reset) begin
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  // monitor + store scoreboard
  always @(negedge clk) begin
    if (array_start) begin
      starts_n++;
      if (acc_clear) clears_n++;
    end
    if (store_valid && store_ready) begin
      stores_n++;
      if (exp_q.size() == 0) begin
        check("store_unexpected", {16'h0, tile_row, tile_col}, 32'hFFFF_FFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("store_order", {16'h0, tile_row, tile_col}, {16'h0, exp_e});
      end
    end
    if (job_done) dones_n++;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cfg(input int m, input int k, input int p);
    cfg_valid   = 1'b1;
    cfg_m_tiles = DIM_W'(m);
    cfg_k_tiles = DIM_W'(k);
    cfg_p_tiles = DIM_W'(p);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!job_done && c < budget) begin
      step();
      c++;
    end
    check("job_done_seen", {31'b0, job_done}, 32'd1);
  endtask

  task automatic mark();
    b_s  = starts_n;
    b_c  = clears_n;
    b_st = stores_n;
    b_d  = dones_n;
  endtask

  initial begin
    // reset state
    repeat (3) step();
    check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("rst_busy_start_store_done_err", {28'b0, busy, array_start, store_valid, job_done}, 32'd0);
    check("rst_err_acc_clear", {30'b0, err, acc_clear}, 32'd0);
    check("rst_perf", perf_cycles, 32'd0);
    check("rst_indices", {8'b0, tile_row, tile_col, tile_k}, 32'd0);
    reset = 1'b0;
    step();

    // 1x1x1 job; nine empty WAIT cycles precede done, so 13 busy cycles total
    done_lat = 10;
    store_ready = 1'b1;
    mark();
    exp_q.push_back(16'h0000);
    send_cfg(1, 1, 1);
    check("t1_start_pulse", {31'b0, array_start}, 32'd1);
    check("t1_acc_clear", {31'b0, acc_clear}, 32'd1);
    wait_done(100);
    step();
    check("t1_starts", starts_n - b_s, 32'd1);
    check("t1_clears", clears_n - b_c, 32'd1);
    check("t1_stores", stores_n - b_st, 32'd1);
    check("t1_dones", dones_n - b_d, 32'd1);
    check("t1_perf", perf_cycles, 32'd13);
    check("t1_err", {31'b0, err}, 32'd0);
    check("t1_idle", {31'b0, cfg_ready}, 32'd1);

    // 2x3x2 job with store always ready
    done_lat = 3;
    mark();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0101);
    send_cfg(2, 3, 2);
    wait_done(400);
    step();
    check("t2_starts", starts_n - b_s, 32'd12);
    check("t2_clears", clears_n - b_c, 32'd4);
    check("t2_stores", stores_n - b_st, 32'd4);
    check("t2_dones", dones_n - b_d, 32'd1);
    check("t2_err", {31'b0, err}, 32'd0);
    check("t2_exp_q_empty", exp_q.size(), 32'd0);

    // store back-pressure for 5 cycles, plus a spurious done while in STORE
    store_ready = 1'b0;
    mark();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    send_cfg(1, 1, 2);
    n = 0;
    while (!store_valid && n < 50) begin
      step();
      n++;
    end
    check("t3_store_valid_seen", {31'b0, store_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", {31'b0, store_valid}, 32'd1);
      check("t3_hold_idx", {8'b0, tile_row, tile_col, tile_k}, 32'd0);
      check("t3_no_start", starts_n - b_s, 32'd1);
      spur_done = (i == 1);
      step();
    end
    spur_done = 1'b0;
    check("t3_spurious_err", {31'b0, err}, 32'd1);
    check("t3_still_storing", {31'b0, store_valid}, 32'd1);
    store_ready = 1'b1;
    wait_done(100);
    step();
    check("t3_starts", starts_n - b_s, 32'd2);
    check("t3_stores", stores_n - b_st, 32'd2);
    check("t3_dones", dones_n - b_d, 32'd1);
    check("t3_err_sticky", {31'b0, err}, 32'd1);

    // zero k count: no starts, err, immediate finish
    mark();
    send_cfg(2, 0, 2);
    check("t4_finish", {31'b0, job_done}, 32'd1);
    check("t4_err", {31'b0, err}, 32'd1);
    step();
    check("t4_idle", {31'b0, cfg_ready}, 32'd1);
    check("t4_no_start", starts_n - b_s, 32'd0);
    check("t4_dones", dones_n - b_d, 32'd1);
    exp_q.push_back(16'h0000);
    send_cfg(1, 1, 1);
    check("t4_err_cleared", {31'b0, err}, 32'd0);
    wait_done(100);
    step();
    check("t4_next_job_err", {31'b0, err}, 32'd0);

    // abort during WAIT of tile (0,1,k=1)
    done_lat = 6;
    mark();
    exp_q.push_back(16'h0000);
    send_cfg(2, 2, 2);
    n = 0;
    while (!(array_start && tile_row == 8'd0 && tile_col == 8'd1 && tile_k == 8'd1) && n < 200) begin
      step();
      n++;
    end
    check("t5_target_start_seen", {31'b0, array_start}, 32'd1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_err_on_abort", {31'b0, err}, 32'd1);
    n = 0;
    while (!array_done && n < 20) begin
      check("t5_no_early_done", {31'b0, job_done}, 32'd0);
      step();
      n++;
    end
    check("t5_array_done_seen", {31'b0, array_done}, 32'd1);
    step();
    check("t5_finish", {31'b0, job_done}, 32'd1);
    check("t5_err", {31'b0, err}, 32'd1);
    repeat (6) step();
    check("t5_starts", starts_n - b_s, 32'd4);
    check("t5_stores", stores_n - b_st, 32'd1);
    check("t5_dones", dones_n - b_d, 32'd1);
    check("t5_idle", {31'b0, cfg_ready}, 32'd1);

    // asynchronous reset in the middle of WAIT
    done_lat = 20;
    mark();
    send_cfg(1, 1, 1);
    step();
    check("t6_busy_before", {31'b0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_ready_busy", {30'b0, cfg_ready, busy}, 32'd2);
    check("t6_rst_outs", {27'b0, array_start, store_valid, job_done, err, acc_clear}, 32'd0);
    check("t6_rst_perf", perf_cycles, 32'd0);
    check("t6_rst_idx", {8'b0, tile_row, tile_col, tile_k}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (25) step();
    check("t6_no_job_done", dones_n - b_d, 32'd0);
    check("t6_starts", starts_n - b_s, 32'd1);
    check("t6_err", {31'b0, err}, 32'd0);
    check("t6_idle", {31'b0, cfg_ready}, 32'd1);

    check("final_exp_q_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
